gray_run_ctrl: RTL and testbench
================================

Name: gray_run_ctrl

Overview:
- Sequencer for the 3-bit gray counter. Accepts a run command over a Start/Busy/Done handshake.
- Clears the counter, issues a gated burst of `CtrEn` cycles, counts wrap events and captures the final code.
- Sits between a command source (bench or control FSM) and one gray counter instance. Drives that counter's `Reset`/`En` and observes its `Output`/`Overflow`.

Parameters:
- `CNT_W`, 8, width of the step-count field and of the remaining-step counter.
- `GRAY_W`, 3, width of the counter code captured in `LastValue`.
- `WRAP_W`, 8, width of the saturating wrap counter.

Ports:
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high reset of all controller state.
- `Start` in 1: run request; sampled only in IDLE.
- `Steps` in `CNT_W`: enable count (Mode 0), or step limit with 0 = unlimited (Mode 1); latched on Start.
- `Mode` in 1: 0 = fixed step count; 1 = run until the first wrap; latched on Start.
- `Abort` in 1: terminates RUN early.
- `Busy` out 1: high from the cycle after Start is accepted through the DONE cycle inclusive.
- `Done` out 1: one-cycle completion pulse.
- `Aborted` out 1: status for the last run, valid from Done until the next Start.
- `TimedOut` out 1: Mode 1 only; step limit reached before any wrap.
- `WrapCnt` out `WRAP_W`: wrap events in the last run; saturates at all-ones.
- `LastValue` out `GRAY_W`: counter code captured in DRAIN.
- `CtrClr` out 1: one-cycle clear pulse to the counter's `Reset`.
- `CtrEn` out 1: counter enable.
- `CtrValue` in `GRAY_W`: counter `Output`.
- `CtrOverflow` in 1: counter `Overflow`.

Behaviour:
- Reset (async) values: state=IDLE, and all outputs 0 (`Busy`, `Done`, `Aborted`, `TimedOut`, `WrapCnt`, `LastValue`, `CtrClr`, `CtrEn`). Reset mid-run also drops `CtrEn` immediately; no Done is produced.
- FSM has five states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - On Start, latch `Steps`/`Mode` and clear `Aborted`/`TimedOut`/`WrapCnt`.
  - If Mode=0 and Steps=0, go directly to DONE (no `CtrClr`, no `CtrEn`); otherwise go to CLEAR.
  - Start is ignored in every other state. Abort is ignored outside RUN.
- CLEAR: `CtrClr`=1 for exactly one cycle; the overflow-edge register is cleared; next state is RUN.
- RUN:
  - `wrap_evt` = `CtrOverflow` & ~`ovf_q`; `ovf_q` is registered every cycle in RUN.
  - `CtrEn` is combinational: 1 when state=RUN & ~`Abort` & ~(Mode=1 & `wrap_evt`).
  - Each `CtrEn` cycle decrements `remaining`.
  - On each `wrap_evt`, `WrapCnt` increments, saturating.
  - Exit to DRAIN when any of the following holds:
    - Mode 0 and the last step is issued (`remaining`=1 & `CtrEn`).
    - Mode 1 and `wrap_evt` (no En that cycle).
    - Mode 1, limit≠0, last limited step issued: set `TimedOut`.
    - `Abort`: set `Aborted`, no En that cycle.
  - Abort wins over a simultaneous wrap. A wrap in the same cycle as Mode-0 completion is still counted.
- DRAIN: `CtrEn`=0; `LastValue` <= `CtrValue`; a `wrap_evt` here is still counted; next state is DONE.
- DONE: `Done`=1 for one cycle, then IDLE. Start in the cycle after Done is accepted.
- Mode-0 timing (Start sampled at cycle 0): `CtrClr` at cycle 1, `CtrEn` at cycles 2..N+1, DRAIN at N+2, `Done` at N+3.
- `remaining` is `CNT_W` wide; Steps=2^CNT_W−1 must run to completion without wrap of `remaining`.

Decomposition:
- Shared package `gray_pkg`:
  - state enum (IDLE/CLEAR/RUN/DRAIN/DONE);
  - `GRAY_W` default;
  - a `bin2gray` function for the bench.
- One natural sub-module, `edge_rise_det`: registered rising-edge detector on `CtrOverflow` with synchronous clear. Everything else stays in `gray_run_ctrl`.
- The top-level bench instantiates `gray_run_ctrl` plus the existing gray counter.

Test Plan:
- Mode0, Steps=5 -> `CtrClr` at cycle 1; `CtrEn` high exactly 5 cycles; `LastValue`=3'b111; `WrapCnt`=0; `Done` at cycle 8; `Busy` 0 afterwards.
- Mode0, Steps=10 -> 10 enables; `LastValue`=3'b011 (gray of 2); `WrapCnt`=1; `Aborted`=0.
- Mode1, Steps=0 -> exactly 8 enables; `LastValue`=3'b000; `WrapCnt`=1; `TimedOut`=0. Mode1, Steps=4 -> 4 enables; `TimedOut`=1; `LastValue`=3'b110.
- Mode0, Steps=20, Abort high in the 3rd RUN cycle -> only 2 enables; `CtrEn` low that same cycle; `Aborted`=1; `LastValue`=3'b011; `Done` 2 cycles after Abort.
- Mode0, Steps=0 -> no `CtrClr`/`CtrEn`; `Done` at cycle 1. Start pulses while `Busy` -> ignored, enable count unchanged.
- `Reset` asserted mid-RUN between clock edges -> `CtrEn`/`Busy`/`WrapCnt` 0 immediately; after release, a new Start with Steps=3 -> normal run, `LastValue`=3'b010.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the gray-counter run controller: controller
// state encoding, the default counter code width and a binary-to-gray
// helper used by models of the counter.
package gray_pkg;

    localparam int GRAY_W_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

    // Reflected binary code of a counter value.
    function automatic logic [GRAY_W_DEFAULT-1:0] bin2gray(input logic [GRAY_W_DEFAULT-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Registered rising-edge detector. The previous sample of sig_i is held in
// a flop; rise_o is high in any cycle where sig_i is high but was low in
// the previous cycle. A synchronous clear forgets the previous sample so a
// level that is already high is seen as a fresh edge afterwards.
module edge_rise_det (
    input  logic Clk,
    input  logic Reset,
    input  logic clear_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // Remember last cycle's level of the watched signal.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sig_q <= 1'b0;
        end else if (clear_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/gray_run_ctrl.sv
// Run sequencer for a small gray counter. A command accepted in IDLE clears
// the counter, then enables it for a fixed number of steps (Mode 0) or until
// it first wraps (Mode 1, optionally bounded by a step limit). Wrap events
// are counted with saturation and the final counter code is captured before
// a one-cycle Done pulse ends the run.
module gray_run_ctrl
    import gray_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int GRAY_W = GRAY_W_DEFAULT,
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [CNT_W-1:0]  Steps,
    input  logic              Mode,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic              Aborted,
    output logic              TimedOut,
    output logic [WRAP_W-1:0] WrapCnt,
    output logic [GRAY_W-1:0] LastValue,
    output logic              CtrClr,
    output logic              CtrEn,
    input  logic [GRAY_W-1:0] CtrValue,
    input  logic              CtrOverflow
);

    ctrl_state_e       state_q, state_d;
    logic [CNT_W-1:0]  remaining_q;
    logic              mode_q;
    logic              limited_q;
    logic              aborted_q;
    logic              timedOut_q;
    logic [WRAP_W-1:0] wrapCnt_q;
    logic [GRAY_W-1:0] lastValue_q;

    logic inRun;
    logic inDrain;
    logic wrapEvt;
    logic ctrEn;
    logic lastStep;
    logic runExit;

    assign inRun   = (state_q == ST_RUN);
    assign inDrain = (state_q == ST_DRAIN);

    // The counter's overflow is a level/pulse; only its rising edge is a
    // wrap. The edge memory is wiped while the counter is being cleared so
    // a stale level from a previous run cannot mask the first wrap.
    edge_rise_det u_ovfEdge (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear_i (state_q == ST_CLEAR),
        .sig_i   (CtrOverflow),
        .rise_o  (wrapEvt)
    );

    // In Mode 1 the wrap cycle itself must not advance the counter, so the
    // enable is withheld combinationally in that cycle; Abort likewise.
    assign ctrEn    = inRun & ~Abort & ~(mode_q & wrapEvt);
    assign lastStep = ctrEn & (remaining_q == CNT_W'(1));
    assign runExit  = Abort
                    | (mode_q & wrapEvt)
                    | (~mode_q & lastStep)
                    | (mode_q & limited_q & lastStep);

    // Next-state selection for the run sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = (!Mode && (Steps == '0)) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN: begin
                if (runExit) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, step countdown, run status and wrap bookkeeping.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            remaining_q <= '0;
            mode_q      <= 1'b0;
            limited_q   <= 1'b0;
            aborted_q   <= 1'b0;
            timedOut_q  <= 1'b0;
            wrapCnt_q   <= '0;
            lastValue_q <= '0;
        end else begin
            if ((state_q == ST_IDLE) && Start) begin
                mode_q      <= Mode;
                remaining_q <= Steps;
                limited_q   <= (Steps != '0);
                aborted_q   <= 1'b0;
                timedOut_q  <= 1'b0;
                wrapCnt_q   <= '0;
            end
            if (inRun) begin
                if (ctrEn) begin
                    remaining_q <= remaining_q - 1'b1;
                end
                if (Abort) begin
                    aborted_q <= 1'b1;
                end else if (mode_q && limited_q && lastStep) begin
                    timedOut_q <= 1'b1;
                end
            end
            if ((inRun || inDrain) && wrapEvt && (wrapCnt_q != '1)) begin
                wrapCnt_q <= wrapCnt_q + 1'b1;
            end
            if (inDrain) begin
                lastValue_q <= CtrValue;
            end
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = (state_q == ST_DONE);
    assign CtrClr    = (state_q == ST_CLEAR);
    assign CtrEn     = ctrEn;
    assign Aborted   = aborted_q;
    assign TimedOut  = timedOut_q;
    assign WrapCnt   = wrapCnt_q;
    assign LastValue = lastValue_q;

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Bench for gray_run_ctrl: the controller drives a behavioural 3-bit gray
// counter; runs are issued back to back and each run's observed behaviour
// is compared with hand-derived constants or a run-level reference model.
module tb_gray_run_ctrl;
    import gray_pkg::*;

    localparam int CNT_W  = 8;
    localparam int GRAY_W = 3;
    localparam int WRAP_W = 8;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic [CNT_W-1:0]  Steps = '0;
    logic              Mode = 1'b0;
    logic              Abort = 1'b0;
    logic              Busy, Done, Aborted, TimedOut, CtrClr, CtrEn;
    logic [WRAP_W-1:0] WrapCnt;
    logic [GRAY_W-1:0] LastValue;
    logic [GRAY_W-1:0] CtrValue;
    logic              CtrOverflow;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct packed {
        int             en;
        int             clr;
        int             clrCycle;
        int             firstEn;
        int             done;
        int             busyLow;
        logic           idleBusy;
        logic [7:0]     wrap;
        logic [2:0]     last;
        logic           to;
        logic           ab;
    } runRes_t;

    typedef struct packed {
        int         steps;
        logic       mode;
        int         abortRun;
        int         en;
        int         wrap;
        logic [2:0] last;
        logic       to;
        logic       ab;
        int         done;
    } dirCase_t;

    runRes_t obs;
    logic [GRAY_W-1:0] prevLast = '0;

    gray_run_ctrl #(.CNT_W(CNT_W), .GRAY_W(GRAY_W), .WRAP_W(WRAP_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Steps      (Steps),
        .Mode       (Mode),
        .Abort      (Abort),
        .Busy       (Busy),
        .Done       (Done),
        .Aborted    (Aborted),
        .TimedOut   (TimedOut),
        .WrapCnt    (WrapCnt),
        .LastValue  (LastValue),
        .CtrClr     (CtrClr),
        .CtrEn      (CtrEn),
        .CtrValue   (CtrValue),
        .CtrOverflow(CtrOverflow)
    );

    // Free-running clock, 10 time-unit period.
    always #5 Clk = ~Clk;

    // Behavioural gray counter: synchronous clear, Overflow pulses for one
    // cycle after an enabled step from 7 back to 0.
    logic [GRAY_W-1:0] ctrBin;
    logic              ctrOvf;
    always @(posedge Clk or posedge Reset) begin
        if (Reset || CtrClr) begin
            ctrBin <= '0;
            ctrOvf <= 1'b0;
        end else begin
            ctrOvf <= CtrEn && (ctrBin == 3'd7);
            if (CtrEn) ctrBin <= ctrBin + 1'b1;
        end
    end
    assign CtrValue    = bin2gray(ctrBin);
    assign CtrOverflow = ctrOvf;

    function automatic string fmtRes(input runRes_t r);
        return $sformatf("en=%0d clr=%0d@%0d firstEn=%0d done=%0d busyLow=%0d idleBusy=%0b wrap=%0d last=%b to=%b ab=%b",
                         r.en, r.clr, r.clrCycle, r.firstEn, r.done, r.busyLow, r.idleBusy, r.wrap, r.last, r.to, r.ab);
    endfunction

    // Issue one run starting in the cycle after the current one and watch it
    // until Done (bounded). abortRun is the 1-based RUN cycle in which Abort
    // is raised (0 = never); pulseAt starts a 3-cycle burst of stray Starts.
    task automatic doRun(input int steps, input logic mode, input int abortRun, input int pulseAt);
        @(posedge Clk); #1;
        obs = '0;
        obs.clrCycle = -1;
        obs.firstEn  = -1;
        obs.done     = -1;
        obs.idleBusy = Busy | Done;
        Start = 1'b1;
        Steps = steps[CNT_W-1:0];
        Mode  = mode;
        for (int c = 1; c <= 600; c++) begin
            @(posedge Clk); #1;
            Start = (pulseAt > 0) && (c >= pulseAt) && (c < pulseAt + 3);
            if (Start) begin
                Steps = 8'd200;
                Mode  = 1'b1;
            end
            Abort = (abortRun > 0) && (c == abortRun + 1);
            #1;
            if (CtrEn) begin
                obs.en++;
                if (obs.firstEn < 0) obs.firstEn = c;
            end
            if (CtrClr) begin
                obs.clr++;
                if (obs.clrCycle < 0) obs.clrCycle = c;
            end
            if (!Busy) obs.busyLow++;
            if (Done) begin
                obs.done = c;
                break;
            end
        end
        Start = 1'b0;
        Abort = 1'b0;
        obs.wrap = WrapCnt;
        obs.last = LastValue;
        obs.to   = TimedOut;
        obs.ab   = Aborted;
    endtask

    // Run-level reference: decides which exit wins (timeout, wrap or abort)
    // from where each would occur in RUN-cycle numbering.
    task automatic refModel(input int steps, input logic mode, input int abortRun, output runRes_t e);
        int runLen;
        int en;
        e = '0;
        e.clrCycle = -1;
        e.firstEn  = -1;
        if (!mode && steps == 0) begin
            e.done = 1;
            e.last = prevLast;
            return;
        end
        e.clr = 1;
        e.clrCycle = 1;
        if (!mode) begin
            runLen = steps;
            en = steps;
            if (abortRun > 0 && abortRun <= steps) begin
                runLen = abortRun;
                en = abortRun - 1;
                e.ab = 1'b1;
            end
            e.wrap = 8'((en / 8 > 255) ? 255 : en / 8);
        end else begin
            runLen = 9;
            en = 8;
            if (steps != 0 && steps <= 8) begin
                runLen = steps;
                en = steps;
                e.to = 1'b1;
            end
            if (abortRun > 0 && abortRun <= runLen) begin
                runLen = abortRun;
                en = abortRun - 1;
                e.to = 1'b0;
                e.ab = 1'b1;
            end
            e.wrap = (en == 8) ? 8'd1 : 8'd0;
        end
        e.en = en;
        e.firstEn = (en > 0) ? 2 : -1;
        e.last = bin2gray(3'(en % 8));
        e.done = runLen + 3;
    endtask

    task automatic test_reset();
        #2;
        testsRun++;
        if ({Busy, Done, Aborted, TimedOut, WrapCnt, LastValue, CtrClr, CtrEn} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b ab=%b to=%b wrap=%0d last=%b clr=%b en=%b want all 0",
                     Busy, Done, Aborted, TimedOut, WrapCnt, LastValue, CtrClr, CtrEn);
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_directed();
        dirCase_t cases [9];
        runRes_t  exp;
        cases = '{
            '{5,   1'b0, 0, 5,   0,  3'b111, 1'b0, 1'b0, 8},
            '{10,  1'b0, 0, 10,  1,  3'b011, 1'b0, 1'b0, 13},
            '{0,   1'b1, 0, 8,   1,  3'b000, 1'b0, 1'b0, 12},
            '{4,   1'b1, 0, 4,   0,  3'b110, 1'b1, 1'b0, 7},
            '{20,  1'b0, 3, 2,   0,  3'b011, 1'b0, 1'b1, 6},
            '{0,   1'b0, 0, 0,   0,  3'b011, 1'b0, 1'b0, 1},
            '{8,   1'b1, 0, 8,   1,  3'b000, 1'b1, 1'b0, 11},
            '{255, 1'b0, 0, 255, 31, 3'b100, 1'b0, 1'b0, 258},
            '{9,   1'b1, 9, 8,   1,  3'b000, 1'b0, 1'b1, 12}
        };
        for (int i = 0; i < 9; i++) begin
            doRun(cases[i].steps, cases[i].mode, cases[i].abortRun, 0);
            exp = '0;
            exp.clr      = (cases[i].mode || cases[i].steps != 0) ? 1 : 0;
            exp.clrCycle = (exp.clr != 0) ? 1 : -1;
            exp.en       = cases[i].en;
            exp.firstEn  = (cases[i].en > 0) ? 2 : -1;
            exp.done     = cases[i].done;
            exp.wrap     = 8'(cases[i].wrap);
            exp.last     = cases[i].last;
            exp.to       = cases[i].to;
            exp.ab       = cases[i].ab;
            prevLast     = exp.last;
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL directed%0d: got %s want %s", i, fmtRes(obs), fmtRes(exp));
            end
        end
    endtask

    task automatic test_start_ignored();
        runRes_t exp;
        doRun(6, 1'b0, 0, 3);
        exp = '0;
        exp.clr = 1;
        exp.clrCycle = 1;
        exp.en = 6;
        exp.firstEn = 2;
        exp.done = 9;
        exp.last = 3'b101;
        prevLast = exp.last;
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL start_while_busy: got %s want %s", fmtRes(obs), fmtRes(exp));
        end
    endtask

    task automatic test_reset_mid_run();
        runRes_t exp;
        @(posedge Clk); #1;
        Start = 1'b1;
        Steps = 8'd20;
        Mode  = 1'b0;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (12) @(posedge Clk);
        #2;
        testsRun++;
        if ({CtrEn, Busy, WrapCnt} !== {1'b1, 1'b1, 8'd1}) begin
            testsFailed++;
            $display("[TB] FAIL pre_reset_run: got en=%b busy=%b wrap=%0d want en=1 busy=1 wrap=1", CtrEn, Busy, WrapCnt);
        end
        #2;
        Reset = 1'b1;
        #1;
        testsRun++;
        if ({CtrEn, Busy, Done, WrapCnt, LastValue} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_run: got en=%b busy=%b done=%b wrap=%0d last=%b want all 0",
                     CtrEn, Busy, Done, WrapCnt, LastValue);
        end
        @(posedge Clk); #3;
        Reset = 1'b0;
        prevLast = '0;
        doRun(3, 1'b0, 0, 0);
        exp = '0;
        exp.clr = 1;
        exp.clrCycle = 1;
        exp.en = 3;
        exp.firstEn = 2;
        exp.done = 6;
        exp.last = 3'b010;
        prevLast = exp.last;
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL run_after_reset: got %s want %s", fmtRes(obs), fmtRes(exp));
        end
    endtask

    task automatic test_back_to_back();
        runRes_t exp;
        doRun(3, 1'b0, 0, 0);
        refModel(3, 1'b0, 0, exp);
        prevLast = exp.last;
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back_a: got %s want %s", fmtRes(obs), fmtRes(exp));
        end
        doRun(2, 1'b1, 0, 0);
        refModel(2, 1'b1, 0, exp);
        prevLast = exp.last;
        testsRun++;
        if (obs !== exp || obs.last !== 3'b011 || obs.to !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back_b: got %s want %s", fmtRes(obs), fmtRes(exp));
        end
    endtask

    task automatic test_random();
        runRes_t exp;
        int steps;
        int abortRun;
        logic mode;
        for (int i = 0; i < 30; i++) begin
            mode = 1'($urandom_range(0, 1));
            steps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 20));
            abortRun = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
            doRun(steps, mode, abortRun, 0);
            refModel(steps, mode, abortRun, exp);
            prevLast = exp.last;
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL random%0d (steps=%0d mode=%0b abort=%0d): got %s want %s",
                         i, steps, mode, abortRun, fmtRes(obs), fmtRes(exp));
            end
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
